// File: rtl/adder_pkg.sv
// Shared constants and FSM encoding for the serial nibble adder.
package adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_adder_cin.sv
// 4-bit ripple adder built from four full adders with an explicit carry-in.
module nibble_adder_cin
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/serial_adder_ctrl.sv
// Wide adder that walks one shared nibble adder LSB-first over NIBBLES cycles,
// keeping the ripple carry in a register between slices.
module serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    output logic                        in_ready,
    output logic                        busy,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                        cout,
    output logic                        done
);

    localparam int unsigned W     = NIBBLE_W * NIBBLES;
    localparam int unsigned IDX_W = $clog2(NIBBLES);

    state_t               state_q, state_d;
    logic [W-1:0]         a_q, b_q, acc_q, acc_next, sum_q;
    logic                 carry_q, cout_q;
    logic [IDX_W-1:0]     idx_q;
    logic [NIBBLE_W-1:0]  nib_a, nib_b, nib_sum;
    logic                 nib_cout;
    logic                 accept, last;

    assign accept = start && (state_q == IDLE);
    assign last   = (idx_q == IDX_W'(NIBBLES - 1));
    assign nib_a  = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign nib_b  = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

    nibble_adder_cin u_nibble_adder (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .s    (nib_sum),
        .cout (nib_cout)
    );

    // Partial sum with the current slice merged in; on the last slice this is the full result.
    always_comb begin
        acc_next = acc_q;
        acc_next[idx_q*NIBBLE_W +: NIBBLE_W] = nib_sum;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            acc_q   <= acc_next;
            carry_q <= nib_cout;
            // idx holds on the final slice so it never wraps.
            if (last) begin
                sum_q  <= acc_next;
                cout_q <= nib_cout;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q == RUN) || (state_q == DONE);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed plus random checks of serial_adder_ctrl against an a+b reference.
module tb_serial_adder_ctrl;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, busy, cout, done;
    logic [W-1:0] sum;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .in_ready (in_ready),
        .busy     (busy),
        .sum      (sum),
        .cout     (cout),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until done is seen (bounded); returns the count.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!done && n < 20);
    endtask

    // Raises start with operands, waits through the accept edge, drops start.
    task automatic accept_op(input logic [W-1:0] x, input logic [W-1:0] y);
        a = x;
        b = y;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        logic [W:0] exp;
        exp = ref_add(x, y);
        accept_op(x, y);
        wait_done(n);
        chk({tag, "_latency"}, n, NIBBLES);
        chk({tag, "_sum"}, sum, exp[W-1:0]);
        chk({tag, "_cout"}, cout, exp[W]);
        step();
        chk({tag, "_done_drop"}, done, 0);
        chk({tag, "_ready"}, in_ready, 1);
    endtask

    initial begin
        int n, cnt0;
        logic [W:0] exp;
        logic [W-1:0] x, y;

        // Reset state
        #12;
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_op("basic", 16'h1234, 16'h4321);
        run_op("ripple", 16'hFFFF, 16'h0001);
        run_op("xnib", 16'h0F0F, 16'h00F1);

        // Start pulse and operand changes while busy are ignored
        cnt0 = done_cnt;
        accept_op(16'h1234, 16'h4321);
        step();
        a = 16'hAAAA;
        b = 16'h5555;
        start = 1'b1;
        chk("ign_busy", busy, 1);
        step();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        wait_done(n);
        chk("ign_sum", sum, 16'h5555);
        chk("ign_cout", cout, 0);
        repeat (8) step();
        chk("ign_single_done", done_cnt - cnt0, 1);
        chk("ign_ready", in_ready, 1);
        chk("ign_idle", busy, 0);

        // Reset mid-operation at idx=2
        cnt0 = done_cnt;
        accept_op(16'h7777, 16'h1111);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mrst_sum", sum, 0);
        chk("mrst_cout", cout, 0);
        chk("mrst_ready", in_ready, 1);
        chk("mrst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) step();
        chk("mrst_no_done", done_cnt - cnt0, 0);
        run_op("post_rst", 16'h0001, 16'h0001);

        // Back-to-back with start held
        a = 16'h8000;
        b = 16'h8000;
        start = 1'b1;
        step();
        wait_done(n);
        chk("b2b1_latency", n, NIBBLES);
        chk("b2b1_sum", sum, 16'h0000);
        chk("b2b1_cout", cout, 1);
        a = 16'h0003;
        b = 16'h0004;
        wait_done(n);
        chk("b2b_gap", n, NIBBLES + 2);
        chk("b2b2_sum", sum, 16'h0007);
        chk("b2b2_cout", cout, 0);
        start = 1'b0;
        step();
        step();

        // Random operands against the reference
        for (int i = 0; i < 20; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            exp = ref_add(x, y);
            accept_op(x, y);
            a = W'($urandom);
            b = W'($urandom);
            wait_done(n);
            chk("rnd_latency", n, NIBBLES);
            chk("rnd_result", {15'd0, cout, sum}, {15'd0, exp});
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Multi-cycle wide adder that reuses a single 4-bit carry-in/carry-out nibble adder and sequences it over `NIBBLES` cycles to add two `4*NIBBLES`-bit operands. It accepts operands through a ready/start handshake, walks the nibbles LSB-first while holding the ripple carry in a register, and presents a registered sum plus carry-out with a one-cycle `done` pulse. It sits between switch/operand capture logic and the display path, and trades area for latency against a full-width combinational ripple adder.

## Interface
- `NIBBLES`, 4, number of 4-bit slices; operand width `W = 4*NIBBLES`; legal range 2..8
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; accepted only on a rising edge where `start && in_ready`
- `a`  in  W  first operand, sampled on the accept edge only
- `b`  in  W  second operand, sampled on the accept edge only
- `in_ready`  out  1  high in IDLE only
- `busy`  out  1  high in RUN and DONE
- `sum`  out  W  result of the last completed add; held until the next completion
- `cout`  out  1  carry out of the top nibble of the last completed add
- `done`  out  1  one-cycle pulse; `sum`/`cout` are new in this cycle

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- **IDLE:** `in_ready`=1. On accept:
  - latch `a` and `b` into `a_q` and `b_q`
  - clear `carry_q` to 0
  - clear `idx` to 0
  - clear the partial-sum register `acc_q`
  - go to RUN
- **RUN:** the nibble adder sees `a_q[4*idx+:4]`, `b_q[4*idx+:4]` and `cin=carry_q`. Each edge:
  - write `acc_q[4*idx+:4]` with the nibble sum
  - set `carry_q` to the nibble carry out
  - increment `idx`
- **RUN exit:** when `idx == NIBBLES-1`, the edge also loads `sum` with the completed `acc_q` including the final nibble, loads `cout` with the final carry, and moves to DONE.
- **DONE:** `done`=1 for exactly one cycle, then IDLE unconditionally.
- **Counter width:** `idx` is `$clog2(NIBBLES)` bits. It never wraps within an operation.
- **Arithmetic:** unsigned, modulo 2^W, with `cout` as bit W. `{cout,sum}` equals `a+b` of the accepted operands.
- **`start` while busy:** ignored. It is not queued and has no effect on the in-flight operands.
- **Operand changes after accept:** changes on `a`/`b` have no effect.
- **Reset values:** all outputs are 0 except `in_ready`=1. Internal registers are 0 and the state is IDLE.
- **Reset mid-operation:** aborts immediately. No `done` is issued, and `sum`/`cout` read 0.
- **Back-to-back operation:** `start` held high re-accepts on the first IDLE edge after DONE.

## Timing
- Accept edge E0 moves the FSM to RUN.
- Edges E1..E`NIBBLES` process nibbles 0..`NIBBLES-1`.
- `done`, new `sum` and new `cout` are visible in the cycle after edge E`NIBBLES`.
- `in_ready` rises one cycle after `done`.
- Minimum accept-to-accept interval is `NIBBLES+2` cycles (6 for the default).
- The combinational path per cycle is one 4-bit ripple only. There is no full-width carry chain.
- `sum` and `cout` are stable from `done` until the corresponding edge of the next operation. There are no intermediate glitches on `sum`, because it is loaded only on the final RUN edge.

## Structure
- **Shared package `adder_pkg`:**
  - `NIBBLE_W = 4`
  - FSM state typedef/encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - `2'd3` is illegal and recovers to IDLE
- **Sub-module `nibble_adder_cin`:** a 4-bit ripple adder of four full adders with an explicit `cin` port.
  - The controller instantiates it exactly once.
  - Its carry-in must be driven from `carry_q`, not tied to 0.
- **Controller contents:** FSM, `idx` counter, operand/partial/result registers and handshake logic.

## Test plan
All scenarios use the default `NIBBLES`=4.
- **Basic add:** reset, then accept `a`=0x1234 and `b`=0x4321. Require `done` exactly 5 cycles after the accept edge's cycle, with `sum`=0x5555 and `cout`=0.
- **Full carry ripple:** `a`=0xFFFF, `b`=0x0001. Require `sum`=0x0000, `cout`=1.
- **Carry across nibbles:** `a`=0x0F0F, `b`=0x00F1. Require `sum`=0x1000 and `cout`=0.
- **Ignored start and operand changes:** pulse `start` with `a`=0xAAAA, `b`=0x5555 two cycles after accepting 0x1234+0x4321, and change `a`/`b` during RUN. Require a single `done` with `sum`=0x5555, then `in_ready` back high with no second operation.
- **Reset mid-operation:** deassert `rst_n` during RUN at idx=2. Require immediate `sum`=0, `cout`=0, `in_ready`=1, and no `done` pulse. The next add, 0x0001+0x0001, returns `sum`=0x0002.
- **Back-to-back:** hold `start` high with operands 0x8000+0x8000, then 0x0003+0x0004. Require results `sum`=0x0000/`cout`=1, then `sum`=0x0007/`cout`=0, with `done` pulses 6 cycles apart.
